// File: rtl/hpdcache_repl_ctrl_if.sv
// Signal bundle between the HPDcache replacement controller and its environment.
// master = controller side, slave = refill/directory/policy/hit/victim side.
interface hpdcache_repl_ctrl_if #(
  parameter int SETS = 0,
  parameter int WAYS = 0
);
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WAY_W = (WAYS > 0) ? WAYS : 1;

  logic             refill_valid_i;
  logic             refill_ready_o;
  logic [SET_W-1:0] refill_set_i;

  logic             dir_rd_o;
  logic [SET_W-1:0] dir_rd_set_o;
  logic [WAY_W-1:0] dir_valid_i;

  logic             repl_o;
  logic [SET_W-1:0] repl_set_o;
  logic [WAY_W-1:0] repl_dir_valid_o;
  logic             repl_updt_plru_o;
  logic [WAY_W-1:0] victim_way_i;

  logic             updt_o;
  logic [SET_W-1:0] updt_set_o;
  logic [WAY_W-1:0] updt_way_o;

  logic             hit_valid_i;
  logic             hit_ready_o;
  logic [SET_W-1:0] hit_set_i;
  logic [WAY_W-1:0] hit_way_i;

  logic             victim_valid_o;
  logic             victim_ready_i;
  logic [SET_W-1:0] victim_set_o;
  logic [WAY_W-1:0] victim_way_o;
  logic             victim_evict_o;

  logic [31:0]      cnt_repl_o;
  logic [31:0]      cnt_evict_o;

  modport master (
    input  refill_valid_i, refill_set_i, dir_valid_i, victim_way_i,
           hit_valid_i, hit_set_i, hit_way_i, victim_ready_i,
    output refill_ready_o, dir_rd_o, dir_rd_set_o,
           repl_o, repl_set_o, repl_dir_valid_o, repl_updt_plru_o,
           updt_o, updt_set_o, updt_way_o, hit_ready_o,
           victim_valid_o, victim_set_o, victim_way_o, victim_evict_o,
           cnt_repl_o, cnt_evict_o
  );

  modport slave (
    output refill_valid_i, refill_set_i, dir_valid_i, victim_way_i,
           hit_valid_i, hit_set_i, hit_way_i, victim_ready_i,
    input  refill_ready_o, dir_rd_o, dir_rd_set_o,
           repl_o, repl_set_o, repl_dir_valid_o, repl_updt_plru_o,
           updt_o, updt_set_o, updt_way_o, hit_ready_o,
           victim_valid_o, victim_set_o, victim_way_o, victim_evict_o,
           cnt_repl_o, cnt_evict_o
  );
endinterface

// File: rtl/hpdcache_repl_ctrl.sv
// HPDcache replacement controller: victim selection for refills and PLRU hit updates.
// Optional statistics counters are enabled with macro HPDCACHE_REPL_CTRL_STATS_EN.
module hpdcache_repl_ctrl #(
  parameter int SETS = 0,
  parameter int WAYS = 0
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  hpdcache_repl_ctrl_if.master  bus
);
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WAY_W = (WAYS > 0) ? WAYS : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIR_WAIT = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [SET_W-1:0] req_set;
  logic [WAY_W-1:0] vic_way;
  logic             vic_evict;
  logic             repl_act;
  logic             all_valid;

  logic             pend_valid;
  logic [SET_W-1:0] pend_set;
  logic [WAY_W-1:0] pend_way;

  assign repl_act  = (state == DIR_WAIT);
  assign all_valid = &bus.dir_valid_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.refill_valid_i) state_nxt = DIR_WAIT;
      DIR_WAIT: state_nxt = RESP;
      RESP:     if (bus.victim_ready_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_set <= '0;
    end else if (state == IDLE && bus.refill_valid_i) begin
      req_set <= bus.refill_set_i;
    end
  end

  // Policy answer is only valid in the repl_o cycle, so capture it there.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vic_way   <= '0;
      vic_evict <= 1'b0;
    end else if (repl_act) begin
      vic_way   <= bus.victim_way_i;
      vic_evict <= all_valid;
    end
  end

  assign bus.refill_ready_o   = (state == IDLE);
  assign bus.dir_rd_o         = (state == IDLE) && bus.refill_valid_i;
  assign bus.dir_rd_set_o     = bus.refill_set_i;

  assign bus.repl_o           = repl_act;
  assign bus.repl_updt_plru_o = repl_act;
  assign bus.repl_set_o       = req_set;
  assign bus.repl_dir_valid_o = bus.dir_valid_i;

  assign bus.victim_valid_o   = (state == RESP);
  assign bus.victim_set_o     = req_set;
  assign bus.victim_way_o     = vic_way;
  assign bus.victim_evict_o   = vic_evict;

  // Replacement owns the policy port; a colliding hit parks here for one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid <= 1'b0;
      pend_set   <= '0;
      pend_way   <= '0;
    end else if (repl_act) begin
      if (!pend_valid && bus.hit_valid_i) begin
        pend_valid <= 1'b1;
        pend_set   <= bus.hit_set_i;
        pend_way   <= bus.hit_way_i;
      end
    end else if (pend_valid) begin
      pend_valid <= 1'b0;
    end
  end

  assign bus.hit_ready_o = !pend_valid;

  always_comb begin
    bus.updt_o     = 1'b0;
    bus.updt_set_o = bus.hit_set_i;
    bus.updt_way_o = bus.hit_way_i;
    if (!repl_act) begin
      if (pend_valid) begin
        bus.updt_o     = 1'b1;
        bus.updt_set_o = pend_set;
        bus.updt_way_o = pend_way;
      end else if (bus.hit_valid_i) begin
        bus.updt_o     = 1'b1;
      end
    end
  end

`ifdef HPDCACHE_REPL_CTRL_STATS_EN
  logic [31:0] cnt_repl;
  logic [31:0] cnt_evict;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_repl  <= '0;
      cnt_evict <= '0;
    end else if (repl_act) begin
      if (cnt_repl != 32'hFFFF_FFFF) cnt_repl <= cnt_repl + 32'd1;
      if (all_valid && cnt_evict != 32'hFFFF_FFFF) cnt_evict <= cnt_evict + 32'd1;
    end
  end

  assign bus.cnt_repl_o  = cnt_repl;
  assign bus.cnt_evict_o = cnt_evict;
`else
  assign bus.cnt_repl_o  = 32'd0;
  assign bus.cnt_evict_o = 32'd0;
`endif

endmodule
